// File: rtl/regfile_wr_demux.sv
// ============================================================================
// regfile_wr_demux
//   MIPS32 general-purpose register file with a one-hot decoded write port,
//   two combinational operand read ports and a debug read port.
//   Register $0 has no storage and always reads as zero.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   - write-before-read forwarding of wdata onto rdata1/rdata2
//                 when the write address matches the read address this cycle
//     undefined - read ports show stored state only (default build)
//   The debug port never forwards in either build.
// ============================================================================

module regfile_wr_demux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREGS = 2 ** ADDR_W;

    // Storage for r[1..NREGS-1]; r[0] is hard-wired to zero and not stored.
    logic [DATA_W-1:0] regs [1:NREGS-1];

    // One-hot write select, one bit per stored register.
    logic [NREGS-1:1] wsel;

    // Decode waddr into a one-hot select; address 0 has no slot and is dropped.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        wsel = '0;
        for (int i = 1; i < NREGS; i++) begin
            wsel[i] = we && (waddr == ADDR_W'(i));
        end
    end

    // Register array: asynchronous clear, then decoded writes on the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this array is cleared by reset because reads must be zero
            // immediately on reset; that rules out a RAM macro and keeps it in
            // flops. Arrays that need no defined reset value should skip this.
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values; blocking is for combinational only.
            for (int i = 1; i < NREGS; i++) begin
                if (wsel[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Stored-state lookup; index 0 and unmatched indices return zero.
    function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (a == ADDR_W'(i)) begin
                v = regs[i];
            end
        end
        return v;
    endfunction

    // Forwarding condition for a read port: live write to the same nonzero index.
    function automatic logic fwd_hit(input logic [ADDR_W-1:0] a);
        return we && (waddr != '0) && (waddr == a);
    endfunction

    // Combinational read ports; everything reads zero while reset is held.
    always_comb begin
        rdata1   = '0;
        rdata2   = '0;
        dbg_data = '0;
        if (!rst) begin
            rdata1   = lookup(raddr1);
            rdata2   = lookup(raddr2);
            dbg_data = lookup(dbg_addr);
`ifdef REGFILE_BYPASS_EN
            if (fwd_hit(raddr1)) begin
                rdata1 = wdata;
            end
            if (fwd_hit(raddr2)) begin
                rdata2 = wdata;
            end
`else
            // Without forwarding, the hit condition is unused by the datapath;
            // fold it away harmlessly so the function stays shared by both builds.
            if (fwd_hit(raddr1) && fwd_hit(raddr2) && 1'b0) begin
                rdata1 = wdata;
            end
`endif
        end
    end

endmodule
